// File: rtl/shk_iic_cfg_seq_if.sv
// Shake transaction bus between the config sequencer (master) and the serial engine (slave).
interface shk_iic_cfg_seq_if #(
    parameter int unsigned WD_SHK_DATA = 8,
    parameter int unsigned WD_SHK_ADDR = 16
);
    logic                   m_shk_0_valid;
    logic                   m_shk_0_msync;
    logic [WD_SHK_DATA-1:0] m_shk_0_mdata;
    logic [WD_SHK_DATA-1:0] m_shk_0_mdat1;
    logic [WD_SHK_ADDR-1:0] m_shk_0_maddr;
    logic                   m_shk_0_ready;
    logic                   m_shk_0_ssync;
    logic [WD_SHK_DATA-1:0] m_shk_0_sdata;

    modport master (
        output m_shk_0_valid, m_shk_0_msync, m_shk_0_mdata, m_shk_0_mdat1, m_shk_0_maddr,
        input  m_shk_0_ready, m_shk_0_ssync, m_shk_0_sdata
    );

    modport slave (
        input  m_shk_0_valid, m_shk_0_msync, m_shk_0_mdata, m_shk_0_mdat1, m_shk_0_maddr,
        output m_shk_0_ready, m_shk_0_ssync, m_shk_0_sdata
    );
endinterface

// File: rtl/shk_iic_cfg_seq.sv
// Walks a {dev, reg, data} table and issues one 3-byte shake write per entry, with
// table-driven delays, an inter-transaction gap and a ready timeout.
module shk_iic_cfg_seq #(
    parameter int unsigned NB_CFG_NUM  = 16,
    parameter int unsigned WD_CFG_IDX  = 8,
    parameter int unsigned WD_SHK_DATA = 8,
    parameter int unsigned WD_SHK_ADDR = 16,
    parameter int unsigned NB_DLY_UNIT = 100_000,
    parameter int unsigned NB_TMO_CNT  = 2_000_000,
    parameter int unsigned NB_GAP_CNT  = 1_000
) (
    input  logic                     i_sys_clk,
    input  logic                     i_sys_resetn,
    input  logic                     i_cfg_start,
    output logic                     o_cfg_busy,
    output logic                     o_cfg_done,
    output logic                     o_cfg_err,
    output logic [WD_CFG_IDX-1:0]    o_cfg_idx,
    output logic [WD_CFG_IDX-1:0]    m_tab_addr,
    input  logic [3*WD_SHK_DATA-1:0] m_tab_data,
    shk_iic_cfg_seq_if.master        m_shk
);

    // One shared counter serves WAIT (timeout), GAP and the per-unit count of DELAY.
    localparam int unsigned CntMax0 = (NB_TMO_CNT > NB_GAP_CNT) ? NB_TMO_CNT : NB_GAP_CNT;
    localparam int unsigned CntMax  = (CntMax0 > NB_DLY_UNIT) ? CntMax0 : NB_DLY_UNIT;
    localparam int unsigned CntW    = $clog2(CntMax + 1);

    typedef enum logic [3:0] {
        StIdle, StFetch, StLoad, StDecode, StReq, StByte,
        StWait, StGap, StDelay, StNext, StDone, StErr
    } state_e;

    state_e                 state_q, state_d;
    logic [WD_CFG_IDX-1:0]  idx_q, idx_d;
    logic [WD_SHK_DATA-1:0] dev_q, dev_d;
    logic [WD_SHK_DATA-1:0] reg_q, reg_d;
    logic [WD_SHK_DATA-1:0] dat_q, dat_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [1:0]             byte_q, byte_d;
    // Delay units already elapsed; never exceeds dat_q - 1.
    logic [WD_SHK_DATA-1:0] dly_q, dly_d;

    // Read data is not used by a write-only sequencer.
    logic unused_sdata;
    assign unused_sdata = ^{m_shk.m_shk_0_ssync, m_shk.m_shk_0_sdata};

    // State and datapath registers.
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            dev_q   <= '0;
            reg_q   <= '0;
            dat_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            dly_q   <= dly_d;
        end
    end

    // Next-state and counter updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        dly_d   = dly_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (i_cfg_start) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    cnt_d   = '0;
                    byte_d  = '0;
                    dly_d   = '0;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                {dev_d, reg_d, dat_d} = m_tab_data;
                state_d = StDecode;
            end
            StDecode: begin
                cnt_d  = '0;
                byte_d = '0;
                dly_d  = '0;
                if (dev_q == '1) begin
                    // A zero-length delay skips DELAY entirely.
                    state_d = (dat_q == '0) ? StNext : StDelay;
                end else begin
                    state_d = StReq;
                end
            end
            StReq: state_d = StByte;
            StByte: begin
                if (byte_q == 2'd2) begin
                    byte_d  = '0;
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    byte_d = byte_q + 2'd1;
                end
            end
            StWait: begin
                if (m_shk.m_shk_0_ready) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else if (cnt_q == CntW'(NB_TMO_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == CntW'(NB_GAP_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = StNext;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDelay: begin
                if (cnt_q == CntW'(NB_DLY_UNIT - 1)) begin
                    cnt_d = '0;
                    if (dly_q == dat_q - WD_SHK_DATA'(1)) begin
                        dly_d   = '0;
                        state_d = StNext;
                    end else begin
                        dly_d = dly_q + WD_SHK_DATA'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StNext: begin
                if (idx_q == WD_CFG_IDX'(NB_CFG_NUM - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + WD_CFG_IDX'(1);
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        o_cfg_busy          = 1'b0;
        o_cfg_done          = 1'b0;
        o_cfg_err           = 1'b0;
        o_cfg_idx           = idx_q;
        m_tab_addr          = idx_q;
        m_shk.m_shk_0_valid = 1'b0;
        m_shk.m_shk_0_msync = 1'b0;
        m_shk.m_shk_0_mdata = '0;
        m_shk.m_shk_0_mdat1 = '0;
        m_shk.m_shk_0_maddr = '0;
        case (state_q)
            StIdle: ;
            StDone: o_cfg_done = 1'b1;
            StErr:  o_cfg_err  = 1'b1;
            StReq: begin
                o_cfg_busy          = 1'b1;
                m_shk.m_shk_0_valid = 1'b1;
                m_shk.m_shk_0_maddr = WD_SHK_ADDR'(idx_q);
            end
            StByte: begin
                o_cfg_busy          = 1'b1;
                m_shk.m_shk_0_msync = 1'b1;
                case (byte_q)
                    2'd0:    m_shk.m_shk_0_mdata = dev_q;
                    2'd1:    m_shk.m_shk_0_mdata = reg_q;
                    default: m_shk.m_shk_0_mdata = dat_q;
                endcase
            end
            default: o_cfg_busy = 1'b1;
        endcase
    end

endmodule
